// File: rtl/fp_posit_pkg.sv
// Shared types and helpers for the bit-serial posit weight path.
package fp_posit_pkg;

  localparam int PREC_W = 4;

  // What the registered outputs show during the current cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Keep the requested width inside 2..max_prec; the MAC cannot decode
  // a 0- or 1-bit posit, and the shifter is only max_prec wide.
  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] cfg,
                                                   input logic [PREC_W-1:0] max_prec);
    if (cfg < PREC_W'(2)) return PREC_W'(2);
    if (cfg > max_prec)   return max_prec;
    return cfg;
  endfunction

endpackage

// File: rtl/posit_shift_reg.sv
// Weight shifter plus down-counter. The MSB of a word is emitted on the
// same edge that loads it, so the register keeps only the bits still to
// send and the counter tracks how many of them remain.
module posit_shift_reg
  import fp_posit_pkg::*;
#(
  parameter int MAX_PREC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [MAX_PREC-1:0] word,
  input  logic [PREC_W-1:0]   prec,
  output logic                word_msb,
  output logic                sh_msb,
  output logic                last
);

  logic [MAX_PREC-1:0] sh_q;
  logic [PREC_W-1:0]   cnt_q;
  logic [PREC_W-1:0]   top_idx;

  assign top_idx = prec - PREC_W'(1);
  // Zero remaining means the bit on the wire is the final one.
  assign last    = (cnt_q == '0);

  // Pick bit prec-1 of the incoming word and of the shifter.
  always_comb begin
    word_msb = 1'b0;
    sh_msb   = 1'b0;
    for (int i = 0; i < MAX_PREC; i++) begin
      if (PREC_W'(i) == top_idx) begin
        word_msb = word[i];
        sh_msb   = sh_q[i];
      end
    end
  end

  // Load drops the MSB being emitted; shift advances one bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sh_q  <= word << 1;
      cnt_q <= prec - PREC_W'(1);
    end else if (shift) begin
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - PREC_W'(1);
    end
  end

endmodule

// File: rtl/posit_weight_serializer.sv
// Parallel-to-serial posit weight transmitter feeding fp_posit_mac.
// One word of buffering lets the next weight start on the cycle after
// the previous last bit; first-flagged weights get a set pulse ahead.
module posit_weight_serializer
  import fp_posit_pkg::*;
#(
  parameter int MAX_PREC = 8  // legal 2..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREC_W-1:0]   precision_cfg,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_PREC-1:0] in_weight,
  input  logic                in_first,
  output logic                valid,
  output logic                w,
  output logic [PREC_W-1:0]   precision,
  output logic                set,
  output logic                busy
);

  state_t              state_q, state_d;
  logic                hold_full, hold_first;
  logic [MAX_PREC-1:0] hold_w;
  logic [PREC_W-1:0]   prec_q;
  logic                accept, load, shift;
  logic                valid_d, w_d, set_d;
  logic                word_msb, sh_msb, last;

  assign accept    = in_valid & ~hold_full;
  assign in_ready  = ~hold_full;
  assign busy      = (state_q != ST_IDLE) | hold_full;
  assign precision = prec_q;

  posit_shift_reg #(.MAX_PREC(MAX_PREC)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .word     (hold_w),
    .prec     (prec_q),
    .word_msb (word_msb),
    .sh_msb   (sh_msb),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: a finished word behaves like idle when picking what follows.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hold_full) state_d = hold_first ? ST_SET : ST_SHIFT;
      ST_SET:   state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (last) begin
          if (hold_full) state_d = hold_first ? ST_SET : ST_SHIFT;
          else           state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: values for the output flops plus shifter controls.
  always_comb begin
    load    = 1'b0;
    shift   = 1'b0;
    set_d   = 1'b0;
    valid_d = 1'b0;
    w_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full) begin
          if (hold_first) set_d = 1'b1;
          else            load  = 1'b1;
        end
      end
      ST_SET:  load = 1'b1;
      ST_SHIFT: begin
        if (!last) shift = 1'b1;
        else if (hold_full) begin
          if (hold_first) set_d = 1'b1;
          else            load  = 1'b1;
        end
      end
      default: ;
    endcase
    if (load) begin
      valid_d = 1'b1;
      w_d     = word_msb;
    end else if (shift) begin
      valid_d = 1'b1;
      w_d     = sh_msb;
    end
  end

  // Registered serial outputs; w is forced low outside valid by decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      w     <= 1'b0;
      set   <= 1'b0;
    end else begin
      valid <= valid_d;
      w     <= w_d;
      set   <= set_d;
    end
  end

  // Holding register: a new write wins over the clear from a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full  <= 1'b0;
      hold_first <= 1'b0;
      hold_w     <= '0;
    end else if (accept) begin
      hold_full  <= 1'b1;
      hold_first <= in_first;
      hold_w     <= in_weight;
    end else if (load) begin
      hold_full  <= 1'b0;
    end
  end

  // Precision tracks the config only while nothing is queued or in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prec_q <= PREC_W'(MAX_PREC);
    else if (state_q == ST_IDLE && !hold_full)
      prec_q <= clamp_prec(precision_cfg, PREC_W'(MAX_PREC));
  end

endmodule

// File: tb/tb_posit_weight_serializer.sv
// Bench for posit_weight_serializer: vector table, hand-written corner
// sequences and a randomized stream checked against a timing-aware model.
module tb_posit_weight_serializer;

  localparam int MAX_PREC = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          precision_cfg;
  logic                in_valid, in_ready, in_first;
  logic [MAX_PREC-1:0] in_weight;
  logic                valid, w, set, busy;
  logic [3:0]          precision;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  cfg;
    logic [7:0]  weight;
    logic        first;
    logic [3:0]  exp_prec;
    logic [15:0] exp_bits;  // right-aligned, sent MSB-first
  } vec_t;

  typedef struct {
    logic [1:0] sym;    // 0/1 = data bit, 2 = set pulse
    int         avail;  // first sample index at which it may appear
  } ev_t;

  vec_t vecs[8];
  ev_t  q[$];

  always #5 clk = ~clk;

  posit_weight_serializer #(.MAX_PREC(MAX_PREC)) dut (
    .clk           (clk),
    .rst           (rst),
    .precision_cfg (precision_cfg),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_weight     (in_weight),
    .in_first      (in_first),
    .valid         (valid),
    .w             (w),
    .precision     (precision),
    .set           (set),
    .busy          (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_prec(input int cfg);
    if (cfg < 2) return 2;
    if (cfg > MAX_PREC) return MAX_PREC;
    return cfg;
  endfunction

  // One word from idle; cycle-exact check of set, bits and return to idle.
  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    int    p;
    nm = $sformatf("vec%0d", idx);
    p  = int'(v.exp_prec);
    precision_cfg = v.cfg;
    in_weight     = v.weight;
    in_first      = v.first;
    in_valid      = 1'b1;
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    tick();
    if (v.first) begin
      chk({nm, "_set"}, 32'({valid, set, w}), 32'b010);
      tick();
    end
    chk({nm, "_prec"}, 32'(precision), 32'(v.exp_prec));
    for (int i = 0; i < p; i++) begin
      chk($sformatf("%s_bit%0d", nm, i), 32'({valid, set, w}),
          32'({1'b1, 1'b0, v.exp_bits[p-1-i]}));
      tick();
    end
    chk({nm, "_idle"}, 32'({valid, set, w, busy}), 32'd0);
  endtask

  // Two words offered back to back; ev/es/ew hold expected valid/set/w
  // per sample, bit i = i-th sample after the first word's output starts.
  task automatic run_pair(input string nm, input logic [3:0] cfg, input logic [3:0] cfg2,
                          input logic [7:0] w1, input logic f1,
                          input logic [7:0] w2, input logic f2,
                          input int n, input logic [31:0] ev, input logic [31:0] es,
                          input logic [31:0] ew, input logic [3:0] eprec);
    logic wa;
    precision_cfg = cfg;
    in_weight     = w1;
    in_first      = f1;
    in_valid      = 1'b1;
    tick();
    precision_cfg = cfg2;
    in_weight     = w2;
    in_first      = f2;
    for (int i = 0; i < n; i++) begin
      wa = in_valid & in_ready;
      tick();
      if (wa) begin
        in_valid = 1'b0;
        in_first = 1'b0;
      end
      chk($sformatf("%s_c%0d", nm, i), 32'({valid, set, w}), 32'({ev[i], es[i], ew[i]}));
      if (i == 0)     chk({nm, "_ready"}, 32'(in_ready), 32'd1);
      if (i == n - 2) chk({nm, "_prec"}, 32'(precision), 32'(eprec));
    end
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    in_valid      = 1'b0;
    in_first      = 1'b0;
    in_weight     = '0;
    precision_cfg = 4'd4;
    #12;
    chk("rst_valid",     32'(valid),     32'd0);
    chk("rst_w",         32'(w),         32'd0);
    chk("rst_set",       32'(set),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_precision", 32'(precision), 32'(MAX_PREC));
    rst = 1'b1;
    tick();

    vecs[0] = '{cfg: 4'd4,  weight: 8'b0000_1011, first: 1'b0, exp_prec: 4'd4, exp_bits: 16'b1011};
    vecs[1] = '{cfg: 4'd4,  weight: 8'hF9,        first: 1'b1, exp_prec: 4'd4, exp_bits: 16'b1001};
    vecs[2] = '{cfg: 4'd8,  weight: 8'hA5,        first: 1'b0, exp_prec: 4'd8, exp_bits: 16'hA5};
    vecs[3] = '{cfg: 4'd1,  weight: 8'b0000_1110, first: 1'b0, exp_prec: 4'd2, exp_bits: 16'b10};
    vecs[4] = '{cfg: 4'd15, weight: 8'h81,        first: 1'b1, exp_prec: 4'd8, exp_bits: 16'h81};
    vecs[5] = '{cfg: 4'd0,  weight: 8'h01,        first: 1'b0, exp_prec: 4'd2, exp_bits: 16'b01};
    vecs[6] = '{cfg: 4'd6,  weight: 8'b1010_0110, first: 1'b0, exp_prec: 4'd6, exp_bits: 16'b100110};
    vecs[7] = '{cfg: 4'd3,  weight: 8'b1111_1101, first: 1'b1, exp_prec: 4'd3, exp_bits: 16'b101};
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], k);
      tick();
    end

    // 1011 then 0110: eight contiguous bits
    run_pair("b2b", 4'd4, 4'd4, 8'b1011, 1'b0, 8'b0110, 1'b0,
             9, 32'h0FF, 32'h0, 32'h6D, 4'd4);
    tick();
    // A5 then first-flagged 3C: one set cycle between them
    run_pair("first2", 4'd8, 4'd8, 8'hA5, 1'b0, 8'h3C, 1'b1,
             18, 32'h1FEFF, 32'h100, 32'h78A5, 4'd8);
    tick();
    // config moves to 6 while busy: both words still use width 4
    run_pair("cfgbusy", 4'd4, 4'd6, 8'b11_0101, 1'b0, 8'b10_1110, 1'b0,
             9, 32'h0FF, 32'h0, 32'h7A, 4'd4);
    tick();
    chk("prec_reload6", 32'(precision), 32'd6);
    precision_cfg = 4'd1;
    tick();
    chk("prec_clamp2", 32'(precision), 32'd2);

    // reset after two bits of 1101
    precision_cfg = 4'd4;
    in_weight     = 8'b1101;
    in_first      = 1'b0;
    in_valid      = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_bit0", 32'({valid, set, w}), 32'b101);
    tick();
    chk("mid_bit1", 32'({valid, set, w}), 32'b101);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out",   32'({valid, set, w}), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),        32'd1);
    chk("mid_rst_busy",  32'(busy),            32'd0);
    chk("mid_rst_prec",  32'(precision),       32'(MAX_PREC));
    #2 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_rst_c%0d", i), 32'({valid, set, w, in_ready}), 32'b0001);
    end

    // randomized streams; config fixed within a batch
    for (int b = 0; b < 5; b++) begin
      int         cfg, prec, sent, cyc;
      logic       acc;
      logic [2:0] want;
      ev_t        e;
      cfg  = (b == 0) ? 1 : int'($urandom_range(0, 15));
      prec = ref_prec(cfg);
      precision_cfg = 4'(cfg);
      in_valid = 1'b0;
      sent = 0;
      cyc  = 0;
      q.delete();
      tick();
      while ((sent < 40 || q.size() != 0) && cyc < 3000) begin
        in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
        in_weight = 8'($urandom);
        in_first  = ($urandom_range(0, 3) == 0);
        acc = in_valid & in_ready;
        tick();
        cyc++;
        if (acc) begin
          sent++;
          e.avail = cyc + 1;
          if (in_first) begin
            e.sym = 2'd2;
            q.push_back(e);
          end
          for (int i = prec - 1; i >= 0; i--) begin
            e.sym = {1'b0, in_weight[i]};
            q.push_back(e);
          end
        end
        want = 3'b000;
        if (q.size() != 0 && q[0].avail <= cyc) begin
          e = q.pop_front();
          want = (e.sym == 2'd2) ? 3'b010 : {2'b10, e.sym[0]};
        end
        chk($sformatf("rand%0d_c%0d", b, cyc), 32'({valid, set, w}), 32'(want));
      end
      in_valid = 1'b0;
      chk($sformatf("rand%0d_drain", b), 32'(q.size()), 32'd0);
      tick();
      chk($sformatf("rand%0d_idle", b), 32'({valid, set, busy, in_ready}), 32'b0001);
      chk($sformatf("rand%0d_prec", b), 32'(precision), 32'(prec));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_weight_serializer.md
# posit_weight_serializer

Transmit side of the bit-serial weight interface consumed by `fp_posit_mac`. Accepts parallel posit weights through a valid/ready handshake, buffers one word ahead, and drives them MSB-first on `w` with `valid`, `precision` and `set`, matching what the MAC expects. Back-to-back weights stream with no idle cycles. A one-cycle `set` pulse is inserted ahead of any weight flagged as the start of a new accumulation.

## Interface
- `MAX_PREC`, 8: widest posit weight in bits; legal range 2..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-low.
- `precision_cfg`  in  4  requested weight width in bits; sampled only while idle.
- `in_valid`  in  1  parallel weight offered.
- `in_ready`  out  1  holding register empty; the word is accepted when `in_valid & in_ready`.
- `in_weight`  in  MAX_PREC  posit weight, right-aligned; bit `precision-1` is sent first.
- `in_first`  in  1  this weight starts a new accumulation; a `set` pulse precedes it.
- `valid`  out  1  `w` carries a weight bit this cycle.
- `w`  out  1  serial weight bit, MSB-first.
- `precision`  out  4  latched weight width, driven to the MAC.
- `set`  out  1  one-cycle accumulation-start pulse to the MAC.
- `busy`  out  1  shifter or holding register occupied.

## Operation
- Datapath has three parts:
  - Holding register: `hold_w`, `hold_first`, `hold_full`.
  - Shift register: `MAX_PREC` bits.
  - Bit counter: 4 bits, counts down.
- `in_ready = ~hold_full`. An accepted word is written to the holding register.
- Precision latching:
  - `prec_q` reloads every cycle while state is IDLE and `hold_full=0`. It is frozen otherwise.
  - A `precision_cfg` value below 2 is clamped to 2. A value above MAX_PREC is clamped to MAX_PREC.
- FSM states: IDLE, SET, SHIFT.
  - IDLE: if `hold_full` and `hold_first`, go to SET. If `hold_full` and not `hold_first`, load the shifter from hold, clear `hold_full`, go to SHIFT.
  - SET: drive `set=1`, `valid=0`. Load the shifter from hold, clear `hold_full`, go to SHIFT.
  - SHIFT: drive `valid=1` and `w = shifter[prec_q-1]`; shift left; decrement the counter. On the last bit (counter==1):
    - Hold full, not first: load from hold in the same cycle and stay in SHIFT. `valid` stays high and there is no bubble.
    - Hold full and first: go to SET.
    - Otherwise: go to IDLE.
- If the holding register is freed and a new word is offered in the same cycle, the holding register is written and `hold_full` stays 1. Write takes priority over clear.
- Outputs are registered: `valid`, `w`, `set` come from flops.
- `busy = (state!=IDLE) | hold_full`.
- `w=0` whenever `valid=0`.

## Timing
- Reset values: `valid=0`, `w=0`, `set=0`, `in_ready=1`, `busy=0`, `precision=MAX_PREC`, state IDLE, holding register empty.
- Latency for an accept at cycle N while idle:
  - Non-first word: MSB appears at N+1.
  - First word: `set` at N+1, MSB at N+2.
- Each weight occupies exactly `prec_q` consecutive `valid` cycles.
- A back-to-back non-first weight follows the previous last bit with no gap.
- A first-flagged successor inserts exactly one `valid=0` cycle, carrying `set=1`.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - The partially sent weight and the held weight are discarded.
  - No partial `set` is emitted after release.

## Structure
- Shared package `fp_posit_pkg` holds:
  - The FSM state enum.
  - `PREC_W=4`.
  - The clamp function for precision.
- One sub-module is natural: `posit_shift_reg`, which holds the shifter plus down-counter with load, shift and last-bit outputs.
- The holding register and FSM stay in the top module.

## Test plan
- Precision 4, weight `4'b1011`, no first: `valid` high 4 cycles starting N+1; `w`=1,0,1,1; then `valid=0`, `busy=0`.
- Precision 4, weights `4'b1011` then `4'b0110` back-to-back: 8 contiguous `valid` cycles; `w`=1,0,1,1,0,1,1,0; `in_ready` high again during the first word.
- Precision 4, `in_first=1` with `4'b1001`: `set=1` with `valid=0` at N+1; `w`=1,0,0,1 at N+2..N+5.
- Precision 8, `8'hA5` followed by first-flagged `8'h3C`: `w`=10100101; one `set` cycle; then `w`=00111100.
- `rst` low after 2 bits of `4'b1101`: `valid`/`w`/`set` are 0 immediately. After release, `in_ready=1` and no further bits of that weight appear.
- `precision_cfg` changed from 4 to 6 while busy: the current and held words use 4. `precision_cfg=1` while idle yields `precision=2`.
